// File: rtl/icmp_rx_parser.sv
// ICMP receive parser: checks the 8-byte header, stores echo data into the receive RAM and
// reports done/err/drop. Define ICMP_RX_CKSUM_EN to build the checksum check.
module icmp_rx_parser #(
  parameter int RAM_AW = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              reply_busy,
  output logic              ram_wr_en,
  output logic [RAM_AW-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic              pkt_drop,
  output logic [15:0]       icmp_id,
  output logic [15:0]       icmp_seq,
  output logic [RAM_AW:0]   data_len,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  // Stream handshake: in_valid qualifies in_data/in_last for one cycle; there is no
  // backpressure, every valid byte is consumed in the cycle it is presented.
  logic [2:0]        state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        code_q, code_d;
  logic [15:0]       id_q, id_d;
  logic [15:0]       seq_q, seq_d;
  logic [RAM_AW:0]   data_cnt_q, data_cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [RAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [15:0]       icmp_id_q, icmp_id_d;
  logic [15:0]       icmp_seq_q, icmp_seq_d;
  logic [RAM_AW:0]   data_len_q, data_len_d;
  logic              acc_start;
  logic              acc_add;
  logic              cksum_ok;
  logic              good;

  assign good = (type_q == 8'd8) && (code_q == 8'd0) && !ovf_q && cksum_ok;

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    type_d     = type_q;
    code_d     = code_q;
    id_d       = id_q;
    seq_d      = seq_q;
    data_cnt_d = data_cnt_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    drop_d     = 1'b0;
    icmp_id_d  = icmp_id_q;
    icmp_seq_d = icmp_seq_q;
    data_len_d = data_len_q;
    acc_start  = 1'b0;
    acc_add    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (reply_busy) begin
            if (in_last) drop_d = 1'b1;
            else         state_d = S_DROP;
          end else begin
            type_d     = in_data;
            hdr_cnt_d  = 3'd1;
            data_cnt_d = '0;
            ovf_d      = 1'b0;
            acc_start  = 1'b1;
            if (in_last) err_d = 1'b1;
            else         state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (in_valid) begin
          acc_add   = 1'b1;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          case (hdr_cnt_q)
            3'd1:    code_d       = in_data;
            3'd4:    id_d[15:8]   = in_data;
            3'd5:    id_d[7:0]    = in_data;
            3'd6:    seq_d[15:8]  = in_data;
            3'd7:    seq_d[7:0]   = in_data;
            default: ;
          endcase
          // Byte 7 ending the packet is a legal zero-length echo request.
          if (hdr_cnt_q == 3'd7) begin
            data_cnt_d = '0;
            state_d    = in_last ? S_CHK : S_DATA;
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (in_valid) begin
          acc_add = 1'b1;
          if (data_cnt_q[RAM_AW]) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = data_cnt_q[RAM_AW-1:0];
            wr_data_d  = in_data;
            data_cnt_d = data_cnt_q + 1'b1;
          end
          if (in_last) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (good) begin
          done_d     = 1'b1;
          icmp_id_d  = id_q;
          icmp_seq_d = seq_q;
          data_len_d = data_cnt_q;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_DROP: begin
        if (in_valid && in_last) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hdr_cnt_q  <= '0;
      type_q     <= '0;
      code_q     <= '0;
      id_q       <= '0;
      seq_q      <= '0;
      data_cnt_q <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      icmp_id_q  <= '0;
      icmp_seq_q <= '0;
      data_len_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      type_q     <= type_d;
      code_q     <= code_d;
      id_q       <= id_d;
      seq_q      <= seq_d;
      data_cnt_q <= data_cnt_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      icmp_id_q  <= icmp_id_d;
      icmp_seq_q <= icmp_seq_d;
      data_len_q <= data_len_d;
    end
  end

`ifdef ICMP_RX_CKSUM_EN
  // Even-offset bytes are word high bytes; an odd trailing byte is implicitly zero-padded.
  logic [31:0] acc_q, acc_d;
  logic        odd_q, odd_d;
  logic [15:0] word;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    word  = odd_q ? {8'h00, in_data} : {in_data, 8'h00};
    acc_d = acc_q;
    odd_d = odd_q;
    if (acc_start) begin
      acc_d = {16'h0000, in_data, 8'h00};
      odd_d = 1'b1;
    end else if (acc_add) begin
      acc_d = acc_q + {16'h0000, word};
      odd_d = ~odd_q;
    end
    fold1    = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    fold2    = fold1[15:0] + {15'h0000, fold1[16]};
    cksum_ok = (fold2 == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      odd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      odd_q <= odd_d;
    end
  end
`else
  logic unused_acc_ctrl;
  assign unused_acc_ctrl = acc_start ^ acc_add;
  assign cksum_ok        = 1'b1;
`endif

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign pkt_done    = done_q;
  assign pkt_err     = err_q;
  assign pkt_drop    = drop_q;
  assign icmp_id     = icmp_id_q;
  assign icmp_seq    = icmp_seq_q;
  assign data_len    = data_len_q;
  assign dbg_state   = state_q;

endmodule
